day1_instruction_sequencer: RTL and testbench

//  Front-end controller for the day-1 dial solver. Consumes the raw puzzle text as a byte stream
//  ("L68\nR48\n..."), parses each line into direction + decimal count, and issues one instruction
//  at a time to the solver over its valid/ready port. On end-of-input it drains the solver, latches

---
 rtl/day1_pkg.sv | 28 ++
 rtl/day1_decimal_accumulator.sv | 54 +++++
 rtl/day1_instruction_sequencer.sv | 152 +++++++++++++++
 tb/tb_day1_instruction_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/day1_pkg.sv
// Shared constants for the day-1 dial front end: ASCII codes, FSM encodings
// and default widths.
package day1_pkg;

  localparam int COUNT_WIDTH_DEFAULT  = 16;
  localparam int RESULT_WIDTH_DEFAULT = 32;

  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  typedef logic [2:0] state_t;

  localparam state_t ST_WAIT_DIR = 3'd0;
  localparam state_t ST_DIGITS   = 3'd1;
  localparam state_t ST_ISSUE    = 3'd2;
  localparam state_t ST_DRAIN    = 3'd3;
  localparam state_t ST_DONE     = 3'd4;
  localparam state_t ST_ERROR    = 3'd5;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/day1_decimal_accumulator.sv
// Decimal accumulator for one instruction line: acc = acc*10 + digit, with a
// digit counter and a look-ahead overflow flag for the digit being presented.
module day1_decimal_accumulator
  import day1_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   digit_strobe,
  input  logic [3:0]             digit,
  output logic [COUNT_WIDTH-1:0] acc,
  output logic                   has_digits,
  output logic                   overflow
);

  localparam int WIDE = COUNT_WIDTH + 4;

  logic [COUNT_WIDTH-1:0] acc_q, acc_d;
  logic [3:0]             ndig_q, ndig_d;
  logic [WIDE-1:0]        wide_next;

  // Four extra bits hold (2^N-1)*10+9 exactly, so overflow is seen before any truncation.
  always_comb begin
    wide_next = ({4'b0000, acc_q} * WIDE'(10)) + WIDE'(digit);
    overflow  = |wide_next[WIDE-1:COUNT_WIDTH];
    acc_d     = acc_q;
    ndig_d    = ndig_q;
    if (clear) begin
      acc_d  = '0;
      ndig_d = '0;
    end else if (digit_strobe && !overflow) begin
      acc_d = wide_next[COUNT_WIDTH-1:0];
      if (ndig_q != '1) begin
        ndig_d = ndig_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      ndig_q <= '0;
    end else begin
      acc_q  <= acc_d;
      ndig_q <= ndig_d;
    end
  end

  assign acc        = acc_q;
  assign has_digits = (ndig_q != '0);

endmodule

// File: rtl/day1_instruction_sequencer.sv
// Byte-stream parser that turns "L68\nR48\n..." into valid/ready instructions
// for the dial solver, then drains the solver and latches its results.
module day1_instruction_sequencer
  import day1_pkg::*;
#(
  parameter int COUNT_WIDTH  = COUNT_WIDTH_DEFAULT,
  parameter int RESULT_WIDTH = RESULT_WIDTH_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  input  logic                    end_of_input,
  output logic                    direction,
  output logic [COUNT_WIDTH-1:0]  count,
  output logic                    instruction_valid,
  input  logic                    instruction_ready,
  input  logic                    busy,
  input  logic [RESULT_WIDTH-1:0] sol_hits,
  input  logic [RESULT_WIDTH-1:0] sol_passes,
  output logic [RESULT_WIDTH-1:0] final_hits,
  output logic [RESULT_WIDTH-1:0] final_passes,
  output logic [15:0]             instr_issued,
  output logic                    done,
  output logic                    error
);

  state_t                  state_q, state_d;
  logic                    dir_q, dir_d;
  logic                    eoi_q, eoi_d;
  logic [15:0]             issued_q, issued_d;
  logic [RESULT_WIDTH-1:0] final_hits_q, final_hits_d;
  logic [RESULT_WIDTH-1:0] final_passes_q, final_passes_d;

  logic                    byte_fire;
  logic                    acc_clear;
  logic                    acc_strobe;
  logic                    acc_overflow;
  logic                    acc_has_digits;
  logic [COUNT_WIDTH-1:0]  acc_value;

  day1_decimal_accumulator #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_acc (
    .clk         (clock),
    .rst         (reset),
    .clear       (acc_clear),
    .digit_strobe(acc_strobe),
    .digit       (byte_in[3:0]),
    .acc         (acc_value),
    .has_digits  (acc_has_digits),
    .overflow    (acc_overflow)
  );

  assign byte_ready = !reset && ((state_q == ST_WAIT_DIR) || (state_q == ST_DIGITS));
  assign byte_fire  = byte_valid && byte_ready;

  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    eoi_d          = eoi_q | end_of_input;
    issued_d       = issued_q;
    final_hits_d   = final_hits_q;
    final_passes_d = final_passes_q;
    acc_clear      = 1'b0;
    acc_strobe     = 1'b0;

    case (state_q)
      ST_WAIT_DIR: begin
        if (byte_fire) begin
          if ((byte_in == ASCII_L) || (byte_in == ASCII_R)) begin
            dir_d     = (byte_in == ASCII_R);
            acc_clear = 1'b1;
            state_d   = ST_DIGITS;
          end else if ((byte_in != ASCII_LF) && (byte_in != ASCII_CR)) begin
            state_d = ST_ERROR;
          end
        end else if (eoi_d) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DIGITS: begin
        if (byte_fire) begin
          if (is_digit(byte_in)) begin
            if (acc_overflow) begin
              state_d = ST_ERROR;
            end else begin
              acc_strobe = 1'b1;
            end
          end else if (byte_in == ASCII_LF) begin
            state_d = acc_has_digits ? ST_ISSUE : ST_ERROR;
          end else if (byte_in != ASCII_CR) begin
            state_d = ST_ERROR;
          end
        end else if (eoi_d) begin
          // A bare direction letter is dropped; a line with digits must be newline-terminated.
          state_d = acc_has_digits ? ST_ERROR : ST_WAIT_DIR;
        end
      end

      ST_ISSUE: begin
        if (instruction_ready) begin
          issued_d = issued_q + 16'd1;
          state_d  = ST_WAIT_DIR;
        end
      end

      ST_DRAIN: begin
        if (!busy && instruction_ready) begin
          final_hits_d   = sol_hits;
          final_passes_d = sol_passes;
          state_d        = ST_DONE;
        end
      end

      ST_DONE, ST_ERROR: begin
      end

      default: state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_WAIT_DIR;
      dir_q          <= 1'b0;
      eoi_q          <= 1'b0;
      issued_q       <= '0;
      final_hits_q   <= '0;
      final_passes_q <= '0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      eoi_q          <= eoi_d;
      issued_q       <= issued_d;
      final_hits_q   <= final_hits_d;
      final_passes_q <= final_passes_d;
    end
  end

  assign direction         = dir_q;
  assign count             = acc_value;
  assign instruction_valid = (state_q == ST_ISSUE);
  assign instr_issued      = issued_q;
  assign final_hits        = final_hits_q;
  assign final_passes      = final_passes_q;
  assign done              = (state_q == ST_DONE);
  assign error             = (state_q == ST_ERROR);

endmodule

// File: tb/tb_day1_instruction_sequencer.sv
// Bench for the day-1 instruction sequencer with a behavioural one-click-per-cycle
// dial solver (starts at 50, 0..99) and a scoreboard of issued instructions.
module tb_day1_instruction_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        end_of_input;
  logic        direction;
  logic [15:0] count;
  logic        instruction_valid;
  logic        instruction_ready;
  logic        busy;
  logic [31:0] sol_hits;
  logic [31:0] sol_passes;
  logic [31:0] final_hits;
  logic [31:0] final_passes;
  logic [15:0] instr_issued;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  day1_instruction_sequencer #(
    .COUNT_WIDTH (16),
    .RESULT_WIDTH(32)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .end_of_input     (end_of_input),
    .direction        (direction),
    .count            (count),
    .instruction_valid(instruction_valid),
    .instruction_ready(instruction_ready),
    .busy             (busy),
    .sol_hits         (sol_hits),
    .sol_passes       (sol_passes),
    .final_hits       (final_hits),
    .final_passes     (final_passes),
    .instr_issued     (instr_issued),
    .done             (done),
    .error            (error)
  );

  // ---------------- behavioural dial solver ----------------
  logic [6:0]  pos;
  logic [15:0] rem;
  logic        sdir;
  logic        hold_ready;

  assign instruction_ready = !busy && !hold_ready;

  function automatic logic [6:0] dial_step(input logic [6:0] p, input logic d);
    if (d) return (p == 7'd99) ? 7'd0 : p + 7'd1;
    return (p == 7'd0) ? 7'd99 : p - 7'd1;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      pos        <= 7'd50;
      rem        <= '0;
      sdir       <= 1'b0;
      busy       <= 1'b0;
      sol_hits   <= '0;
      sol_passes <= '0;
    end else if (busy) begin
      if (rem == 16'd0) begin
        busy <= 1'b0;
        if (pos == 7'd0) sol_hits <= sol_hits + 32'd1;
      end else begin
        pos <= dial_step(pos, sdir);
        if (dial_step(pos, sdir) == 7'd0) sol_passes <= sol_passes + 32'd1;
        rem <= rem - 16'd1;
      end
    end else if (instruction_valid && instruction_ready) begin
      busy <= 1'b1;
      rem  <= count;
      sdir <= direction;
    end
  end

  // ---------------- bookkeeping ----------------
  typedef struct packed {
    logic        dir;
    logic [15:0] cnt;
  } instr_t;

  typedef struct {
    bit send_eoi;
    bit exp_done;
    bit exp_err;
    int exp_hits;
    int exp_passes;
    int exp_issued;
  } vec_t;

  localparam int NV = 10;

  int          n_checks = 0;
  int          n_fail   = 0;
  instr_t      exp_q[$];
  logic        m_dir;
  int          m_cnt;
  int          m_nd;
  logic [15:0] last_issued;
  bit          seen_valid;
  vec_t        vecs[NV];
  string       texts[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting, got no event, required event", name);
  endtask

  // Expected instruction pushed when its terminating newline is handed to the DUT.
  task automatic model_byte(input logic [7:0] c);
    if (c == 8'h4C || c == 8'h52) begin
      m_dir = (c == 8'h52);
      m_cnt = 0;
      m_nd  = 0;
    end else if (c >= 8'h30 && c <= 8'h39) begin
      m_cnt = m_cnt * 10 + (int'(c) - 48);
      m_nd++;
    end else if (c == 8'h0A) begin
      if (m_nd > 0 && m_cnt <= 65535) exp_q.push_back({m_dir, 16'(m_cnt)});
      m_nd = 0;
    end
  endtask

  task automatic monitor_step();
    instr_t e;
    if (reset) begin
      last_issued = instr_issued;
    end else begin
      if (instruction_valid) seen_valid = 1'b1;
      if (instr_issued != last_issued) begin
        check("issued_step", 64'(instr_issued), 64'(last_issued + 16'd1));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got dir=%0d count=%0d, required no instruction", direction, count);
        end else begin
          e = exp_q.pop_front();
          check("sb_dir", 64'(direction), 64'(e.dir));
          check("sb_count", 64'(count), 64'(e.cnt));
        end
        last_issued = instr_issued;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b1;
    byte_valid   = 1'b0;
    end_of_input = 1'b0;
    hold_ready   = 1'b0;
    exp_q.delete();
    m_nd         = 0;
    seen_valid   = 1'b0;
    #1;
    check("reset_byte_ready_low", 64'(byte_ready), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_reset_byte_ready", 64'(byte_ready), 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] c, output bit aborted);
    int budget;
    aborted = 1'b0;
    @(negedge clock);
    byte_in    = c;
    byte_valid = 1'b1;
    budget     = 0;
    while (!byte_ready && !error && budget < 5000) begin
      @(negedge clock);
      budget++;
    end
    if (!byte_ready) begin
      byte_valid = 1'b0;
      aborted    = 1'b1;
      if (!error) timeout_fail("byte_accept");
      return;
    end
    model_byte(c);
    @(posedge clock);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_text(input string s);
    bit ab;
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], ab);
      if (ab) break;
    end
  endtask

  task automatic pulse_eoi();
    @(negedge clock);
    end_of_input = 1'b1;
    @(negedge clock);
    end_of_input = 1'b0;
  endtask

  task automatic wait_end();
    int budget = 0;
    while (!done && !error && budget < 20000) begin
      @(negedge clock);
      budget++;
    end
    if (!done && !error) timeout_fail("wait_done_or_error");
  endtask

  task automatic wait_valid();
    int budget = 0;
    while (!instruction_valid && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    if (!instruction_valid) timeout_fail("wait_instruction_valid");
  endtask

  initial begin
    bit ab;
    reset        = 1'b1;
    byte_in      = 8'h00;
    byte_valid   = 1'b0;
    end_of_input = 1'b0;
    hold_ready   = 1'b0;
    seen_valid   = 1'b0;
    last_issued  = '0;
    m_dir        = 1'b0;
    m_cnt        = 0;
    m_nd         = 0;

    fork
      forever begin
        @(negedge clock);
        monitor_step();
      end
    join_none

    texts[0] = "L68\nL30\nR48\nL5\nR60\nL55\nL1\nL99\nR14\nL82\n";
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 3, 6, 10};
    texts[1] = "R1000\r\n";
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 0, 10, 1};
    texts[2] = "X";
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 0, 0, 0};
    texts[3] = "R\n";
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 0, 0, 0};
    texts[4] = "5\n";
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 0, 0, 0};
    texts[5] = "\nR5\n\r\n";
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 0, 0, 1};
    texts[6] = "R4\nL";
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 0, 0, 1};
    texts[7] = "L12";
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0};
    texts[8] = "L0\nR0\nR50\n";
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1, 1, 3};
    texts[9] = "L65536\n";
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 0, 0, 0};

    // Reset state while reset is held.
    repeat (3) @(negedge clock);
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_valid", 64'(instruction_valid), 64'd0);
    check("rst_issued", 64'(instr_issued), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_direction", 64'(direction), 64'd0);
    check("rst_final_hits", 64'(final_hits), 64'd0);
    check("rst_final_passes", 64'(final_passes), 64'd0);

    for (int v = 0; v < NV; v++) begin
      do_reset();
      send_text(texts[v]);
      if (vecs[v].send_eoi) pulse_eoi();
      wait_end();
      repeat (2) @(negedge clock);
      check($sformatf("v%0d_done", v), 64'(done), 64'(vecs[v].exp_done));
      check($sformatf("v%0d_error", v), 64'(error), 64'(vecs[v].exp_err));
      check($sformatf("v%0d_final_hits", v), 64'(final_hits), 64'(vecs[v].exp_hits));
      check($sformatf("v%0d_final_passes", v), 64'(final_passes), 64'(vecs[v].exp_passes));
      check($sformatf("v%0d_issued", v), 64'(instr_issued), 64'(vecs[v].exp_issued));
      check($sformatf("v%0d_byte_ready", v), 64'(byte_ready), 64'd0);
      check($sformatf("v%0d_valid", v), 64'(instruction_valid), 64'd0);
      check($sformatf("v%0d_sb_left", v), 64'(exp_q.size()), 64'd0);
    end

    // Solver back-pressure: instruction held stable while ready is low.
    do_reset();
    hold_ready = 1'b1;
    send_text("R7\n");
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("hold_valid", 64'(instruction_valid), 64'd1);
      check("hold_count", 64'(count), 64'd7);
      check("hold_dir", 64'(direction), 64'd1);
      check("hold_byte_ready", 64'(byte_ready), 64'd0);
    end
    hold_ready = 1'b0;
    pulse_eoi();
    wait_end();
    check("hold_done", 64'(done), 64'd1);
    check("hold_issued", 64'(instr_issued), 64'd1);
    check("hold_final_hits", 64'(final_hits), 64'd0);

    // Overflow flagged on the fifth digit, nothing ever issued.
    do_reset();
    send_text("L7000");
    @(negedge clock);
    check("ovf_no_error_4dig", 64'(error), 64'd0);
    send_byte(8'h30, ab);
    @(negedge clock);
    check("ovf_error", 64'(error), 64'd1);
    check("ovf_byte_ready", 64'(byte_ready), 64'd0);
    repeat (3) @(negedge clock);
    check("ovf_never_valid", 64'(seen_valid), 64'd0);

    // Largest legal count reaches the solver port unchanged.
    do_reset();
    hold_ready = 1'b1;
    send_text("R65535\n");
    wait_valid();
    @(negedge clock);
    check("max_count", 64'(count), 64'd65535);
    check("max_no_error", 64'(error), 64'd0);

    // Reset while an instruction is pending; only the later line counts.
    do_reset();
    hold_ready = 1'b1;
    send_text("R3\n");
    wait_valid();
    do_reset();
    check("midrst_valid", 64'(instruction_valid), 64'd0);
    check("midrst_issued", 64'(instr_issued), 64'd0);
    send_text("L50\n");
    pulse_eoi();
    wait_end();
    repeat (2) @(negedge clock);
    check("midrst_done", 64'(done), 64'd1);
    check("midrst_hits", 64'(final_hits), 64'd1);
    check("midrst_passes", 64'(final_passes), 64'd1);
    check("midrst_issued_final", 64'(instr_issued), 64'd1);
    check("midrst_sb_left", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
